// File: rtl/arbiter_puf_engine_if.sv
// rtl/arbiter_puf_engine_if.sv - challenge/response handshake bundle for arbiter_puf_engine
//
// Purpose: groups the request side (start/challenge/mode) and the result side
//          (response/unstable/resp_valid/resp_ready) of the PUF engine.
// Signals:
//    start       request an evaluation (engine input)
//    challenge   C_LENGTH-bit challenge, latched on accept (engine input)
//    mode        0 = single evaluation, 1 = majority vote (engine input)
//    resp_ready  consumer accepts the result (engine input)
//    busy        evaluation in progress (engine output)
//    response    voted response, N_RESP bits (engine output)
//    unstable    per-chain non-unanimous flag, N_RESP bits (engine output)
//    resp_valid  result available (engine output)
// Modports: master = requester/consumer side, slave = engine side.

interface arbiter_puf_engine_if #(
   parameter int C_LENGTH = 8,
   parameter int N_RESP   = 8
);
   logic                start;
   logic [C_LENGTH-1:0] challenge;
   logic                mode;
   logic                busy;
   logic [N_RESP-1:0]   response;
   logic [N_RESP-1:0]   unstable;
   logic                resp_valid;
   logic                resp_ready;

   modport master (
      output start, challenge, mode, resp_ready,
      input  busy, response, unstable, resp_valid
   );

   modport slave (
      input  start, challenge, mode, resp_ready,
      output busy, response, unstable, resp_valid
   );
endinterface

// File: rtl/arbiter_puf_engine.sv
// rtl/arbiter_puf_engine.sv - multi-chain arbiter PUF with majority-vote evaluation controller
//
// Purpose: N_RESP crossed-mux delay chains driven by a registered launch level.
//          Each chain ends in an arbiter flop that is synchronised into clk.
//          The controller evaluates a challenge once or N_EVAL times, counts
//          ones per chain, and returns a voted response plus unstable flags.
// Ports:
//    clk    single clock, rising edge
//    rst_n  asynchronous active-low reset
//    bus    arbiter_puf_engine_if.slave (start/challenge/mode in,
//           busy/response/unstable/resp_valid out, resp_ready in)

module arbiter_puf_engine #(
   parameter int C_LENGTH = 8,
   parameter int N_RESP   = 8,
   parameter int N_EVAL   = 7,
   parameter int SETTLE   = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   arbiter_puf_engine_if.slave bus
);
   localparam int CW = $clog2(N_EVAL + 1);
   localparam int SW = $clog2(SETTLE);

   if (((N_EVAL % 2) == 0) || (N_EVAL < 3)) begin : g_bad_eval
      $error("N_EVAL must be odd and at least 3");
   end
   if (SETTLE < 3) begin : g_bad_settle
      $error("SETTLE must be at least 3");
   end

   typedef enum logic [2:0] {
      S_IDLE, S_LAUNCH, S_HOLD, S_SAMPLE, S_RELAX, S_DONE
   } state_t;

   state_t              r_state, w_state_nxt;
   logic [C_LENGTH-1:0] r_challenge;
   logic                r_mode, r_launch, r_busy, r_resp_valid;
   logic [CW-1:0]       r_eval_cnt;
   logic [SW-1:0]       r_settle_cnt;
   logic [CW-1:0]       r_ones [N_RESP];
   logic [N_RESP-1:0]   r_response, r_unstable, r_sync1, r_arb_s;
   logic [N_RESP-1:0]   w_arb_q, w_resp_nxt, w_unst_nxt;
   logic [C_LENGTH-1:0] w_sel [N_RESP];
   logic                w_accept, w_settle_last, w_transfer, w_launch_nxt;
   logic [CW-1:0]       w_eval_target;

   // Delay chains: both rails start from the launch level; a set select bit
   // crosses the rails at that stage. Chain j uses the challenge rotated by j.
   for (genvar j = 0; j < N_RESP; j++) begin : g_chain
      localparam int ROT = j % C_LENGTH;
      (* keep = "true", dont_touch = "true" *) logic w_rail1_out;
      (* keep = "true", dont_touch = "true" *) logic w_rail2_out;
      logic r_arb;

      assign w_sel[j] = (r_challenge << ROT) | (r_challenge >> ((C_LENGTH - ROT) % C_LENGTH));

      for (genvar k = 0; k < C_LENGTH; k++) begin : g_stage
         (* keep = "true", dont_touch = "true" *) logic w_in1, w_in2, w_out1, w_out2;
         if (k == 0) begin : g_head
            assign w_in1 = r_launch;
            assign w_in2 = r_launch;
         end else begin : g_link
            assign w_in1 = g_stage[k-1].w_out1;
            assign w_in2 = g_stage[k-1].w_out2;
         end
         assign w_out1 = w_sel[j][k] ? w_in2 : w_in1;
         assign w_out2 = w_sel[j][k] ? w_in1 : w_in2;
      end

      assign w_rail1_out = g_stage[C_LENGTH-1].w_out1;
      assign w_rail2_out = g_stage[C_LENGTH-1].w_out2;

      // Arbiter: records whether rail 2 won the race against rail 1.
      always_ff @(posedge w_rail1_out or negedge rst_n) begin
         if (!rst_n) r_arb <= 1'b0;
         else        r_arb <= w_rail2_out;
      end

      assign w_arb_q[j] = r_arb;
   end

   // Arbiter outputs are asynchronous to clk.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= '0;
         r_arb_s <= '0;
      end else begin
         r_sync1 <= w_arb_q;
         r_arb_s <= r_sync1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_eval_target = r_mode ? CW'(N_EVAL) : CW'(1);
      w_settle_last = (r_settle_cnt == SW'(SETTLE - 1));
      w_accept      = (r_state == S_IDLE) && bus.start && !r_resp_valid;
      w_transfer    = (r_state == S_DONE) && r_resp_valid && bus.resp_ready;
      // Launch is high through HOLD and SAMPLE, low through RELAX and LAUNCH.
      w_launch_nxt  = (r_state == S_LAUNCH) || (r_state == S_HOLD);
      case (r_state)
         S_IDLE:   if (w_accept) w_state_nxt = S_LAUNCH;
         S_LAUNCH: w_state_nxt = S_HOLD;
         S_HOLD:   if (w_settle_last) w_state_nxt = S_SAMPLE;
         S_SAMPLE: w_state_nxt = S_RELAX;
         S_RELAX:  if (w_settle_last)
                      w_state_nxt = (r_eval_cnt == w_eval_target) ? S_DONE : S_LAUNCH;
         S_DONE:   if (w_transfer) w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_resp_nxt = '0;
      w_unst_nxt = '0;
      for (int j = 0; j < N_RESP; j++) begin
         if (r_mode) begin
            w_resp_nxt[j] = (r_ones[j] > CW'(N_EVAL / 2));
            w_unst_nxt[j] = (r_ones[j] != '0) && (r_ones[j] != w_eval_target);
         end else begin
            w_resp_nxt[j] = r_ones[j][0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_challenge  <= '0;
         r_mode       <= 1'b0;
         r_launch     <= 1'b0;
         r_busy       <= 1'b0;
         r_resp_valid <= 1'b0;
         r_eval_cnt   <= '0;
         r_settle_cnt <= '0;
         r_response   <= '0;
         r_unstable   <= '0;
         for (int j = 0; j < N_RESP; j++) r_ones[j] <= '0;
      end else begin
         r_launch <= w_launch_nxt;
         if ((r_state == S_HOLD) || (r_state == S_RELAX))
            r_settle_cnt <= w_settle_last ? '0 : r_settle_cnt + SW'(1);
         else
            r_settle_cnt <= '0;
         if (w_accept) begin
            r_challenge <= bus.challenge;
            r_mode      <= bus.mode;
            r_eval_cnt  <= '0;
            r_busy      <= 1'b1;
            for (int j = 0; j < N_RESP; j++) r_ones[j] <= '0;
         end
         if (r_state == S_SAMPLE) begin
            r_eval_cnt <= r_eval_cnt + CW'(1);
            for (int j = 0; j < N_RESP; j++) r_ones[j] <= r_ones[j] + CW'(r_arb_s[j]);
         end
         if (r_state == S_DONE) begin
            if (!r_resp_valid) begin
               r_response   <= w_resp_nxt;
               r_unstable   <= w_unst_nxt;
               r_resp_valid <= 1'b1;
               r_busy       <= 1'b0;
            end else if (bus.resp_ready) begin
               r_resp_valid <= 1'b0;
            end
         end
      end
   end

   assign bus.busy       = r_busy;
   assign bus.response   = r_response;
   assign bus.unstable   = r_unstable;
   assign bus.resp_valid = r_resp_valid;
endmodule

// File: tb/tb_arbiter_puf_engine.sv
// tb/tb_arbiter_puf_engine.sv - randomized self-checking bench for arbiter_puf_engine
module tb_arbiter_puf_engine;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   int n_cmp = 0;
   int n_bad = 0;

   logic       start_d [2];
   logic       mode_d  [2];
   logic       ready_d [2];
   logic [7:0] chal_d  [2];
   logic [7:0] arb_a;
   logic [3:0] arb_b;
   logic [7:0] vq [$];

   arbiter_puf_engine_if #(.C_LENGTH(8), .N_RESP(8)) bus_a ();
   arbiter_puf_engine_if #(.C_LENGTH(8), .N_RESP(4)) bus_b ();

   arbiter_puf_engine #(.C_LENGTH(8), .N_RESP(8), .N_EVAL(7), .SETTLE(4))
      dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
   arbiter_puf_engine #(.C_LENGTH(8), .N_RESP(4), .N_EVAL(3), .SETTLE(3))
      dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

   assign bus_a.start      = start_d[0];
   assign bus_a.mode       = mode_d[0];
   assign bus_a.resp_ready = ready_d[0];
   assign bus_a.challenge  = chal_d[0];
   assign bus_b.start      = start_d[1];
   assign bus_b.mode       = mode_d[1];
   assign bus_b.resp_ready = ready_d[1];
   assign bus_b.challenge  = chal_d[1];

   logic       ob_valid [2], ob_busy [2], ob_launch [2];
   logic [7:0] ob_resp [2], ob_unst [2], ob_sel1 [2], ob_selt [2];
   assign ob_valid[0]  = bus_a.resp_valid;
   assign ob_valid[1]  = bus_b.resp_valid;
   assign ob_busy[0]   = bus_a.busy;
   assign ob_busy[1]   = bus_b.busy;
   assign ob_resp[0]   = bus_a.response;
   assign ob_resp[1]   = {4'h0, bus_b.response};
   assign ob_unst[0]   = bus_a.unstable;
   assign ob_unst[1]   = {4'h0, bus_b.unstable};
   assign ob_launch[0] = dut_a.r_launch;
   assign ob_launch[1] = dut_b.r_launch;
   assign ob_sel1[0]   = dut_a.w_sel[1];
   assign ob_sel1[1]   = dut_b.w_sel[1];
   assign ob_selt[0]   = dut_a.w_sel[7];
   assign ob_selt[1]   = dut_b.w_sel[3];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] rotl(input logic [7:0] c, input int r);
      logic [7:0] o;
      o = '0;
      for (int i = 0; i < 8; i++) o[(i + r) % 8] = c[i];
      return o;
   endfunction

   // Reference: count ones per chain across the queued evaluations.
   function automatic void model(input logic m, input int n_e, output logic [7:0] er, output logic [7:0] eu);
      int cnt;
      er = '0;
      eu = '0;
      for (int j = 0; j < 8; j++) begin
         cnt = 0;
         foreach (vq[e]) cnt += int'(vq[e][j]);
         if (m) begin
            er[j] = (2 * cnt > n_e);
            eu[j] = (cnt != 0) && (cnt != n_e);
         end else begin
            er[j] = vq[0][j];
         end
      end
   endfunction

   task automatic set_arb(input int w, input logic [7:0] v);
      if (w == 0) begin
         arb_a = v;
         force dut_a.w_arb_q = arb_a;
      end else begin
         arb_b = v[3:0];
         force dut_b.w_arb_q = arb_b;
      end
   endtask

   task automatic fill(input int w, input int n);
      vq.delete();
      for (int e = 0; e < n; e++)
         vq.push_back((w == 0) ? 8'($urandom) : 8'($urandom_range(0, 15)));
   endtask

   task automatic run(input int w, input logic m, input logic [7:0] ch, input logic rdy,
                      output logic [7:0] er, output logic [7:0] eu);
      int n_e, per, lat;
      n_e = m ? ((w == 0) ? 7 : 3) : 1;
      per = (w == 0) ? 10 : 8;
      model(m, n_e, er, eu);
      set_arb(w, vq[0]);
      chal_d[w]  = ch;
      mode_d[w]  = m;
      ready_d[w] = rdy;
      start_d[w] = 1'b1;
      @(posedge clk); #1;
      start_d[w] = 1'b0;
      chal_d[w]  = ~ch;
      check("busy_on_accept", ob_busy[w], 1'b1);
      check("sel_chain1", ob_sel1[w], rotl(ch, 1));
      check("sel_chain_last", ob_selt[w], rotl(ch, (w == 0) ? 7 : 3));
      lat = 0;
      while ((ob_valid[w] !== 1'b1) && (lat < 200)) begin
         @(posedge clk); #1;
         lat++;
         if (((lat % per) == 0) && ((lat / per) < n_e)) set_arb(w, vq[lat / per]);
      end
      check("latency", lat, n_e * per + 1);
      check("response", ob_resp[w], er);
      check("unstable", ob_unst[w], eu);
      check("busy_off_at_valid", ob_busy[w], 1'b0);
      if (rdy) begin
         @(posedge clk); #1;
         check("valid_pulse", ob_valid[w], 1'b0);
         check("resp_hold", ob_resp[w], er);
      end
   endtask

   initial begin
      logic [7:0] er, eu;
      logic seen;
      rst_n = 1'b0;
      for (int w = 0; w < 2; w++) begin
         start_d[w] = 1'b0; mode_d[w] = 1'b0; ready_d[w] = 1'b0; chal_d[w] = 8'h00;
      end
      arb_a = '0;
      arb_b = '0;
      repeat (3) @(posedge clk);
      #1;
      for (int w = 0; w < 2; w++) begin
         check("rst_valid", ob_valid[w], 1'b0);
         check("rst_busy", ob_busy[w], 1'b0);
         check("rst_resp", ob_resp[w], 8'h00);
         check("rst_unst", ob_unst[w], 8'h00);
         check("rst_launch", ob_launch[w], 1'b0);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_busy", ob_busy[0], 1'b0);
      check("post_rst_valid", ob_valid[0], 1'b0);

      vq = '{8'h3C};
      run(0, 1'b0, 8'hA5, 1'b1, er, eu);
      vq = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h0F, 8'h0F, 8'h0F};
      run(0, 1'b1, 8'h5A, 1'b1, er, eu);
      vq = '{8'h2D};
      run(0, 1'b0, 8'h01, 1'b1, er, eu);

      for (int i = 0; i < 8; i++) begin
         logic m;
         m = 1'($urandom);
         fill(i % 2, m ? ((i % 2 == 0) ? 7 : 3) : 1);
         run(i % 2, m, 8'($urandom), 1'b1, er, eu);
      end

      // Backpressure with ignored start pulses
      fill(0, 7);
      run(0, 1'b1, 8'($urandom), 1'b0, er, eu);
      for (int c = 0; c < 20; c++) begin
         start_d[0] = c[0];
         @(posedge clk); #1;
         check("bp_valid", ob_valid[0], 1'b1);
         check("bp_resp", ob_resp[0], er);
         check("bp_busy", ob_busy[0], 1'b0);
      end
      start_d[0] = 1'b1;
      ready_d[0] = 1'b1;
      @(posedge clk); #1;
      check("xfer_valid", ob_valid[0], 1'b0);
      check("start_on_release_ignored", ob_busy[0], 1'b0);
      @(posedge clk); #1;
      start_d[0] = 1'b0;
      check("accept_after_release", ob_busy[0], 1'b1);

      // Abort during HOLD of the third evaluation
      repeat (22) @(posedge clk);
      #1;
      check("launch_in_hold", ob_launch[0], 1'b1);
      rst_n = 1'b0;
      #1;
      check("abort_launch", ob_launch[0], 1'b0);
      check("abort_busy", ob_busy[0], 1'b0);
      check("abort_valid", ob_valid[0], 1'b0);
      check("abort_resp", ob_resp[0], 8'h00);
      @(posedge clk); #1;
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (80) begin
         @(posedge clk); #1;
         if (ob_valid[0] === 1'b1) seen = 1'b1;
      end
      check("no_valid_after_abort", seen, 1'b0);
      fill(0, 7);
      run(0, 1'b1, 8'($urandom), 1'b1, er, eu);

      vq = '{8'h05, 8'h05, 8'h06};
      run(1, 1'b1, 8'h01, 1'b1, er, eu);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/arbiter_puf_engine.md
# arbiter_puf_engine

Parametrised multi-chain arbiter PUF with an on-chip evaluation controller. Generates the launch pulse from `clk` rather than feeding `clk` straight into the delay chains. Re-evaluates each challenge up to `N_EVAL` times, majority-votes every response bit and flags unstable bits. Returns the result through a valid/ready handshake. Sits between the top-level I/O wrapper and the challenge/response pins, replacing the free-running single-shot PUF.

## Interface
- `C_LENGTH`, 8: mux stages per delay chain; challenge width.
- `N_RESP`, 8: number of independent chains; response width.
- `N_EVAL`, 7: evaluations per challenge in vote mode; must be odd and ≥3 (elaboration error otherwise).
- `SETTLE`, 4: cycles the launch level is held high, then low, per evaluation; must be ≥3 (elaboration error otherwise).

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request evaluation; accepted only in IDLE with `resp_valid`=0.
- `challenge` in `C_LENGTH`: latched on the accept edge.
- `mode` in 1: latched on the accept edge; 0 = single evaluation, 1 = majority vote over `N_EVAL`.
- `busy` out 1: high from the accept edge until `resp_valid` rises.
- `response` out `N_RESP`: voted response; stable while `resp_valid`=1.
- `unstable` out `N_RESP`: bit j = 1 if the votes for chain j were not unanimous.
- `resp_valid` out 1: result available.
- `resp_ready` in 1: consumer accepts the result.

## Operation
- **Chains.** Chain j (0..`N_RESP`-1) is a crossed-mux delay line of `C_LENGTH` stages.
  - Both rails start from the registered `launch` net.
  - Stage k selects with `chal_j[k]`, where `chal_j` = latched challenge rotated left by j mod `C_LENGTH`.
  - Synthesis keep/dont_touch applies to all chain nets.
- **Arbiter.** Flop `arb_q[j]` is clocked by the rising edge of rail 1 and has rail 2 as D. It is async-cleared by `rst_n`.
- **Synchroniser.** Each `arb_q[j]` passes through a 2-flop synchroniser into `clk`; its output is `arb_s[j]`.
- **FSM states.**
  - IDLE: `launch`=0. On accepted `start`, latch `challenge` and `mode`, clear the vote counters, set `eval_cnt`=0, go to LAUNCH.
  - LAUNCH (1 cycle): `launch`←1, go to HOLD.
  - HOLD (`SETTLE` cycles): `launch` stays 1, go to SAMPLE.
  - SAMPLE (1 cycle): `ones[j]` += `arb_s[j]`, `eval_cnt`++, go to RELAX.
  - RELAX (`SETTLE` cycles): `launch`=0. If `eval_cnt` = E, go to DONE; else go to LAUNCH.
  - DONE: compute outputs and set `resp_valid`=1. Hold until `resp_ready`=1, then clear `resp_valid` and go to IDLE.
- **Evaluation count.** E = `N_EVAL` if mode=1, otherwise 1.
- **Counter width.** `ones[j]` is clog2(`N_EVAL`+1) bits wide and cannot overflow.
- **Vote mode output.** `response[j]` = (`ones[j]` > `N_EVAL`/2, integer division). `unstable[j]` = (`ones[j]`≠0 && `ones[j]`≠E).
- **Single mode output.** `response[j]` = `ones[j]`[0]; `unstable` = 0.
- **Start handling.** `start` while busy, or while `resp_valid`=1, is ignored (not queued). `challenge` changes after the accept edge have no effect.

## Timing
- **Reset values.** `busy`=0, `resp_valid`=0, `response`=0, `unstable`=0, `launch`=0, `arb_q`=0, synchronisers 0, FSM=IDLE.
- **Latency.** `resp_valid` rises E·(2·`SETTLE`+2)+1 edges after the accept edge.
  - Defaults: 71 cycles in vote mode, 11 in single mode.
- **Busy.** `busy` rises on the accept edge and falls on the edge `resp_valid` rises.
- **Handshake.** Transfer occurs on an edge with `resp_valid`=1 and `resp_ready`=1. `resp_valid` is 0 on the next cycle.
  - `resp_ready` held high in advance gives a 1-cycle `resp_valid` pulse.
  - `response` and `unstable` hold their values after transfer until the next DONE.
- **Start on the release cycle.** `start` asserted in the same cycle as the transfer is ignored. The earliest accept is the following cycle.
- **Relax margin.** `launch` is low ≥ `SETTLE` cycles before every rising launch edge, so the chains fully discharge between evaluations.
- **Reset mid-operation.**
  - `launch` drops immediately; all state and outputs return to reset values.
  - No `resp_valid` is produced for the aborted request.

## Test plan
Zero-delay chains race in simulation, so the bench forces `arb_q` hierarchically for each evaluation.
- **Reset defaults.** Reset, then release → all outputs 0 and `busy`=0; `start`=1 with `mode`=0 and `challenge`=0xA5 → `busy`=1 on the next edge.
- **Single mode.** Force `arb_q`=0x3C; `start`, `mode`=0 → `resp_valid` exactly 11 cycles after accept, `response`=0x3C, `unstable`=0x00.
- **Vote mode.** Force `arb_q`=0xFF for 4 evaluations and 0x0F for 3 → `resp_valid` after 71 cycles, `response`=0xFF, `unstable`=0xF0.
- **Backpressure and ignored start.** Hold `resp_ready`=0 for 20 cycles and pulse `start` meanwhile → `resp_valid` and `response` stay stable and no new run starts; raise `resp_ready` → one transfer, then IDLE.
- **Reset mid-operation.** Assert `rst_n`=0 during HOLD of evaluation 3 → `launch`, `busy` and `resp_valid` are 0 immediately; after release, a fresh `start` completes normally.
- **Challenge rotation.** `C_LENGTH`=8, challenge 0x01 → chain 1 select vector = 0x02 and chain 7 = 0x80 (checked on internal selects); repeat with `N_RESP`=4, `N_EVAL`=3 for parameter coverage.
